// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor: one full-adder slice and a carry flop,
// processing one bit per clock LSB first behind a START/BUSY/DONE handshake.
module serial_addsub #(
  parameter int unsigned N = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic         SUB,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         BUSY,
  output logic         DONE,
  output logic [N-1:0] O,
  output logic         COUT
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  r_sh;
  logic          c;
  logic [CW-1:0] cnt;

  logic          sum_c;
  logic          carry_c;
  logic [N-1:0]  r_next_c;

  // Single full-adder slice on the operand LSBs.
  assign sum_c    = a_sh[0] ^ b_sh[0] ^ c;
  assign carry_c  = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
  assign r_next_c = {sum_c, r_sh[N-1:1]};

  assign BUSY = (state == RUN);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      r_sh  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      DONE  <= 1'b0;
      O     <= '0;
      COUT  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            // Subtract is A + ~B + 1: invert B and seed the carry with SUB.
            a_sh  <= A;
            b_sh  <= SUB ? ~B : B;
            c     <= SUB;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_next_c;
          c    <= carry_c;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            O     <= r_next_c;
            COUT  <= carry_c;
            DONE  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: N=8 and N=2 instances, directed vectors.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, sub;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] o;

  logic       start2, sub2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2;
  logic [1:0] o2;

  int checks = 0;
  int errors = 0;

  logic [8:0] q8[$];
  logic [2:0] q2[$];
  logic [7:0] prev_o;

  always #5 clk = ~clk;

  serial_addsub #(.N(8)) dut8 (
    .CLK(clk), .RESET(reset), .START(start), .SUB(sub), .A(a), .B(b),
    .BUSY(busy), .DONE(done), .O(o), .COUT(cout)
  );

  serial_addsub #(.N(2)) dut2 (
    .CLK(clk), .RESET(reset), .START(start2), .SUB(sub2), .A(a2), .B(b2),
    .BUSY(busy2), .DONE(done2), .O(o2), .COUT(cout2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop the expected {COUT,O} whenever a DONE pulse is presented.
  always @(negedge clk) begin
    if (done) begin
      if (q8.size() == 0) check("unexpected_done8", 32'(1), 32'(0));
      else check("result8", 32'({cout, o}), 32'(q8.pop_front()));
    end
    if (done2) begin
      if (q2.size() == 0) check("unexpected_done2", 32'(1), 32'(0));
      else check("result2", 32'({cout2, o2}), 32'(q2.pop_front()));
    end
  end

  // Issue one N=8 operation at the next edge and walk its BUSY/DONE timeline.
  // keep=1 leaves START high with zeroed operands to exercise ignored STARTs.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                        input logic [8:0] expv, input bit keep);
    start = 1'b1; a = av; b = bv; sub = sv;
    q8.push_back(expv);
    tick();
    if (keep) begin
      a = 8'h00; b = 8'h00; sub = 1'b0;
    end else begin
      start = 1'b0;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("busy8", 32'(busy), 32'(1));
      check("done8_early", 32'(done), 32'(0));
      check("o8_hold", 32'(o), 32'(prev_o));
      tick();
    end
    @(negedge clk);
    check("done8", 32'(done), 32'(1));
    check("busy8_end", 32'(busy), 32'(0));
    prev_o = expv[7:0];
  endtask

  task automatic run_op2(input logic [1:0] av, input logic [1:0] bv, input logic sv,
                         input logic [2:0] expv);
    start2 = 1'b1; a2 = av; b2 = bv; sub2 = sv;
    q2.push_back(expv);
    tick();
    start2 = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check("busy2", 32'(busy2), 32'(1));
      check("done2_early", 32'(done2), 32'(0));
      tick();
    end
    @(negedge clk);
    check("done2", 32'(done2), 32'(1));
    check("busy2_end", 32'(busy2), 32'(0));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; sub = 1'b0; a = '0; b = '0;
    start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
    prev_o = 8'h00;
    tick();
    tick();
    @(negedge clk);
    check("rst_busy8", 32'(busy), 32'(0));
    check("rst_done8", 32'(done), 32'(0));
    check("rst_o8", 32'({cout, o}), 32'(0));
    check("rst_busy2", 32'(busy2), 32'(0));
    check("rst_o2", 32'({cout2, o2}), 32'(0));
    reset = 1'b0;
    tick();

    // Plain add, overflow, subtract with and without borrow.
    run_op(8'h35, 8'h4A, 1'b0, 9'h07F, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0);
    run_op(8'h10, 8'h01, 1'b1, 9'h10F, 1'b0);
    run_op(8'h01, 8'h02, 1'b1, 9'h0FF, 1'b0);

    // START held through the run is ignored; 0+0 begins in the DONE cycle.
    run_op(8'h35, 8'h4A, 1'b0, 9'h07F, 1'b1);
    run_op(8'h00, 8'h00, 1'b0, 9'h000, 1'b0);

    // Back-to-back: second START issued in the first operation's DONE cycle.
    run_op(8'h35, 8'h4A, 1'b0, 9'h07F, 1'b0);
    run_op(8'h05, 8'h07, 1'b1, 9'h0FE, 1'b0);

    // Reset in the middle of 0x01+0x01 after a completed 0x35+0x4A.
    run_op(8'h35, 8'h4A, 1'b0, 9'h07F, 1'b0);
    start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    prev_o = 8'h00;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_o", 32'({cout, o}), 32'(0));
    for (int k = 0; k < 10; k++) begin
      tick();
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'(0));
      check("midrst_idle", 32'(busy), 32'(0));
    end
    run_op(8'h02, 8'h03, 1'b0, 9'h005, 1'b0);

    // Narrowest width.
    tick();
    run_op2(2'd3, 2'd1, 1'b1, 3'b110);
    run_op2(2'd0, 2'd1, 1'b1, 3'b011);

    tick();
    tick();
    tick();
    check("q8_drained", 32'(q8.size()), 32'(0));
    check("q2_drained", 32'(q2.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
